// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract controller driving one shared 4-bit ripple adder.
// Optional saturation on signed overflow: define NIBSER_SAT_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end
  assign cout = c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic             Busy,
  output logic             Done
);
  localparam int NIBS = WIDTH / 4;
  localparam int IW   = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0] nib_sum;
  logic       nib_cout;
  logic       ovf_now;
  logic       accept;

  adder4 u_add (
    .a    (areg_q[3:0]),
    .b    (breg_q[3:0]),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  assign ovf_now = (areg_q[3] == breg_q[3]) & (nib_sum[3] != areg_q[3]);

  // Next-state: operand latch on accept, one adder pass per RUN cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    areg_d  = areg_q;
    breg_d  = breg_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) accept = 1'b1;
      end
      RUN: begin
        s_d[{idx_q, 2'b00} +: 4] = nib_sum;
        carry_d = nib_cout;
        areg_d  = areg_q >> 4;
        breg_d  = breg_q >> 4;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          cout_d  = nib_cout;
          ovf_d   = ovf_now;
          state_d = DONE;
`ifdef NIBSER_SAT_EN
          if (ovf_now)
            s_d = {areg_q[3], {(WIDTH-1){~areg_q[3]}}};
`endif
        end
      end
      DONE: begin
        if (Start) accept = 1'b1;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = RUN;
      areg_d  = A;
      breg_d  = Sub ? ~B : B;
      carry_d = Sub;
      idx_d   = '0;
      s_d     = '0;
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      areg_q  <= '0;
      breg_q  <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;
  assign Busy = (state_q == RUN);
  assign Done = (state_q == DONE);

endmodule
